// File: rtl/uart_tx_sequencer_if.sv
// Byte handshake between the TX holding path and the transmit sequencer.
// The source pops its FIFO/TDR on valid_i & ready_o.
interface uart_tx_sequencer_if;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o
    );
endinterface

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: frames one byte as start/data/parity/stop
// on tx_o, bit timing from an internal baud counter.
module uart_tx_sequencer (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   tx_en_i,
    input  logic [15:0]            divisor_i,
    input  logic [7:0]             lcr_i,
    uart_tx_sequencer_if.slave     src,
    output logic                   tx_o,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        stop_q, stop_d;
    logic [7:0]  sdata_q, sdata_d;
    logic [4:0]  slcr_q, slcr_d;
    logic [15:0] sdiv_q, sdiv_d;
    logic        tx_q;
    logic        done_q;
    logic        line_d;
    logic        done_d;
    logic        accept;
    logic        bit_end;
    logic [2:0]  last_idx;
    logic [7:0]  mask;
    logic        par;
    logic        lcr_unused;

    assign lcr_unused = &{1'b0, lcr_i[7:6]};

    assign src.ready_o = (state_q == IDLE) && tx_en_i;
    assign accept      = src.ready_o && src.valid_i;
    assign bit_end     = (cnt_q == 16'd0);
    assign last_idx    = 3'd4 + {1'b0, slcr_q[1:0]};

    always_comb begin
        mask = 8'hFF;
        unique case (slcr_q[1:0])
            2'b00: mask = 8'h1F;
            2'b01: mask = 8'h3F;
            2'b10: mask = 8'h7F;
            2'b11: mask = 8'hFF;
        endcase
    end

    // odd parity is the inverted XOR of the sent bits
    assign par = (^(sdata_q & mask)) ^ ~slcr_q[4];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        sdata_d = sdata_q;
        slcr_d  = slcr_q;
        sdiv_d  = sdiv_q;
        if (state_q != IDLE) begin
            cnt_d = bit_end ? sdiv_q : cnt_q - 16'd1;
        end
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sdata_d = src.data_i;
                    slcr_d  = lcr_i[4:0];
                    sdiv_d  = divisor_i;
                    cnt_d   = divisor_i;
                    idx_d   = 3'd0;
                    stop_d  = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == last_idx) begin
                        stop_d  = 1'b0;
                        state_d = slcr_q[3] ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    stop_d  = 1'b0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (slcr_q[2] && !stop_q) begin
                        stop_d = 1'b1;
                    end else begin
                        cnt_d   = 16'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx_o and done_o are registered, so decode them from next state
    always_comb begin
        line_d = 1'b1;
        case (state_d)
            START:   line_d = 1'b0;
            DATA:    line_d = sdata_d[idx_d];
            PARITY:  line_d = par;
            default: line_d = 1'b1;
        endcase
    end

    assign done_d = (state_d == STOP) && (cnt_d == 16'd0)
                  && (stop_d || !slcr_q[2]);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            stop_q  <= 1'b0;
            sdata_q <= 8'd0;
            slcr_q  <= 5'd0;
            sdiv_q  <= 16'd0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            sdata_q <= sdata_d;
            slcr_q  <= slcr_d;
            sdiv_q  <= sdiv_d;
            tx_q    <= line_d & ~lcr_i[5];
            done_q  <= done_d;
        end
    end

    assign tx_o   = tx_q;
    assign done_o = done_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: frame table plus
// back-to-back, reset, break and enable-drop sequences.
module tb_uart_tx_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tx_en_i = 1'b0;
    logic [15:0] divisor_i = 16'd0;
    logic [7:0]  lcr_i = 8'd0;
    logic        tx_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;

    uart_tx_sequencer_if bus ();

    uart_tx_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_en_i   (tx_en_i),
        .divisor_i (divisor_i),
        .lcr_i     (lcr_i),
        .src       (bus.slave),
        .tx_o      (tx_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  lcr;
        logic [15:0] dv;
        logic [7:0]  data;
        logic [11:0] bits;
        int          nb;
        int          mid_at;
        logic [7:0]  mid_lcr;
        logic [15:0] mid_dv;
        int          brk_on;
        int          brk_off;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // bits[i] is the i-th line bit (start first), each held dv+1 clocks
    task automatic run_vec(input vec_t v, input int id);
        int len;
        int w;
        logic exp_tx;
        len = v.nb * (int'(v.dv) + 1);
        lcr_i       = v.lcr;
        divisor_i   = v.dv;
        bus.data_i  = v.data;
        bus.valid_i = 1'b1;
        tx_en_i     = 1'b1;
        w = 0;
        while (!bus.ready_o && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("v%0d_ready", id), bus.ready_o, 1);
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.data_i  = ~v.data;
        for (int k = 0; k < len; k++) begin
            exp_tx = v.bits[k / (int'(v.dv) + 1)];
            if (k > v.brk_on && k <= v.brk_off) exp_tx = 1'b0;
            chk($sformatf("v%0d_tx_k%0d", id, k), tx_o, exp_tx);
            chk($sformatf("v%0d_busy_k%0d", id, k), busy_o, 1);
            chk($sformatf("v%0d_done_k%0d", id, k), done_o,
                (k == len - 1) ? 1 : 0);
            if (k == v.mid_at) begin
                lcr_i     = v.mid_lcr;
                divisor_i = v.mid_dv;
            end
            if (k == v.brk_on)  lcr_i[5] = 1'b1;
            if (k == v.brk_off) lcr_i[5] = 1'b0;
            @(negedge clk);
        end
        chk($sformatf("v%0d_busy_end", id), busy_o, 0);
        chk($sformatf("v%0d_done_end", id), done_o, 0);
        chk($sformatf("v%0d_tx_end", id), tx_o, 1);
    endtask

    initial begin
        int dn;
        logic exp_tx;

        vecs[0] = '{8'h03, 16'd3, 8'hA5, 12'h34A, 10, -1, 8'h00, 16'd0, -1, -1};
        vecs[1] = '{8'h1E, 16'd1, 8'h41, 12'h682, 11, -1, 8'h00, 16'd0, -1, -1};
        vecs[2] = '{8'h08, 16'd0, 8'hFF, 12'h0BE,  8, -1, 8'h00, 16'd0, -1, -1};
        vecs[3] = '{8'h01, 16'd2, 8'h2A, 12'h0D4,  8, -1, 8'h00, 16'd0, -1, -1};
        vecs[4] = '{8'h1B, 16'd0, 8'h03, 12'h406, 11, -1, 8'h00, 16'd0, -1, -1};
        vecs[5] = '{8'h0E, 16'd0, 8'h80, 12'h700, 11, -1, 8'h00, 16'd0, -1, -1};
        vecs[6] = '{8'h03, 16'd3, 8'hA5, 12'h34A, 10, 10, 8'h00, 16'd7, -1, -1};
        vecs[7] = '{8'h00, 16'd7, 8'h15, 12'h06A,  7, -1, 8'h00, 16'd0, -1, -1};
        vecs[8] = '{8'h03, 16'd3, 8'hA5, 12'h34A, 10, -1, 8'h00, 16'd0, 35, 37};

        bus.valid_i = 1'b0;
        bus.data_i  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_tx", tx_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_ready", bus.ready_o, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // back-to-back 8N1 divisor 0: 0x00 then 0xFF
        lcr_i       = 8'h03;
        divisor_i   = 16'd0;
        bus.data_i  = 8'h00;
        bus.valid_i = 1'b1;
        tx_en_i     = 1'b1;
        chk("b2b_ready0", bus.ready_o, 1);
        @(negedge clk);
        bus.data_i = 8'hFF;
        for (int k = 1; k <= 22; k++) begin
            exp_tx = !(k <= 9 || k == 12);
            chk($sformatf("b2b_tx_k%0d", k), tx_o, exp_tx);
            chk($sformatf("b2b_done_k%0d", k), done_o,
                (k == 10 || k == 21) ? 1 : 0);
            chk($sformatf("b2b_ready_k%0d", k), bus.ready_o,
                (k == 11 || k == 22) ? 1 : 0);
            chk($sformatf("b2b_busy_k%0d", k), busy_o,
                (k == 11 || k == 22) ? 0 : 1);
            if (k == 12) bus.valid_i = 1'b0;
            @(negedge clk);
        end

        // reset in the middle of the data bits
        lcr_i       = 8'h03;
        divisor_i   = 16'd3;
        bus.data_i  = 8'hA5;
        bus.valid_i = 1'b1;
        chk("mrst_ready", bus.ready_o, 1);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("mrst_busy_pre", busy_o, 1);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mrst_tx", tx_o, 1);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_done", done_o, 0);
        reset_n = 1'b1;
        dn = 0;
        repeat (45) begin
            @(negedge clk);
            dn += int'(done_o);
        end
        chk("mrst_nodone", dn, 0);
        chk("mrst_idle_tx", tx_o, 1);

        // enable dropped mid-frame: frame finishes, nothing new accepted
        lcr_i       = 8'h08;
        divisor_i   = 16'd0;
        bus.data_i  = 8'hFF;
        bus.valid_i = 1'b1;
        chk("en_ready", bus.ready_o, 1);
        @(negedge clk);
        tx_en_i = 1'b0;
        dn = 0;
        repeat (15) begin
            dn += int'(done_o);
            @(negedge clk);
        end
        chk("en_done_once", dn, 1);
        chk("en_busy", busy_o, 0);
        chk("en_ready_off", bus.ready_o, 0);
        chk("en_tx", tx_o, 1);
        bus.valid_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
